dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port word data memory (256 x 32, synchronous read, one-cycle read latency). Port 0 is the core load/store unit. Port 1 is the loader/debug path. The block grants one requester per transaction using round-robin. It converts partial-byte stores into read-modify-write sequences and flags out-of-range addresses. Memory-side outputs drive the data memory directly.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 36 +++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    // Sequencer states: accept grants, wait for read data, or finish a read-modify-write.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RMW_WAIT = 2'd2
    } state_t;

    localparam int         DEPTH_WORDS_DEF = 256;
    localparam logic [3:0] BE_FULL         = 4'hF;
    localparam logic [3:0] BE_NONE         = 4'h0;

    // Fields captured from the winning requester at grant time.
    typedef struct packed {
        logic        we;
        logic [29:0] idx;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side bus.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [3:0]  p0_be;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [3:0]  p1_be;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // Arbiter side.
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_be, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_be, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_address, mem_read_en, mem_write_en, mem_write_data,
        input  mem_read_data
    );

    // Requesters and memory side.
    modport master (
        output p0_req, p0_we, p0_addr, p0_be, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_be, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_address, mem_read_en, mem_write_en, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; last_grant = 1 means port 1 won last.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);
    logic last_grant_q;
    logic last_grant_d;

    // Ties go to the port that did not win last time.
    always_comb begin
        gnt0 = req0 & (~req1 | last_grant_q);
        gnt1 = req1 & (~req0 | ~last_grant_q);
    end

    // Remember the winner only when a grant is actually taken.
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = gnt1;
        end
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous-read word memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam logic [31:0] DEPTH_L = DEPTH_WORDS;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    txn_t        txn_q, txn_d;
    logic [1:0]  err_q, err_d;
    logic [1:0]  oor_rv_q, oor_rv_d;

    logic        arb_req0, arb_req1;
    logic        gnt0, gnt1, any_gnt;
    txn_t        win;
    logic        win_oor;
    logic        win_port;
    logic [31:0] merged;
    logic        unused_ok;

    assign unused_ok = ^{bus.p0_addr[1:0], bus.p1_addr[1:0], txn_q.we};

    // Requests are only visible to the picker while idle and out of reset.
    assign arb_req0 = bus.p0_req & (state_q == IDLE) & ~reset;
    assign arb_req1 = bus.p1_req & (state_q == IDLE) & ~reset;
    assign any_gnt  = gnt0 | gnt1;
    assign win_port = gnt1;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req0    (arb_req0),
        .req1    (arb_req1),
        .advance (any_gnt),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    // Select the winning port's fields and range-check its word index.
    always_comb begin
        win.we    = gnt1 ? bus.p1_we    : bus.p0_we;
        win.idx   = gnt1 ? bus.p1_addr[31:2] : bus.p0_addr[31:2];
        win.be    = gnt1 ? bus.p1_be    : bus.p0_be;
        win.wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
        win_oor   = ({2'b00, win.idx} >= DEPTH_L);
    end

    // Byte lanes for the write half of a read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[8*gi +: 8] = txn_q.be[gi] ? txn_q.wdata[8*gi +: 8]
                                                : bus.mem_read_data[8*gi +: 8];
    end

    // State register and latched transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            txn_q    <= '0;
            err_q    <= 2'b00;
            oor_rv_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            txn_q    <= txn_d;
            err_q    <= err_d;
            oor_rv_q <= oor_rv_d;
        end
    end

    // Next state: reads and partial writes need a second cycle, everything else stays idle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        txn_d    = txn_q;
        err_d    = 2'b00;
        oor_rv_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (any_gnt) begin
                    owner_d = win_port;
                    txn_d   = win;
                    if (win_oor) begin
                        err_d[win_port]    = 1'b1;
                        oor_rv_d[win_port] = ~win.we;
                    end else if (!win.we) begin
                        state_d = RD_WAIT;
                    end else if ((win.be != BE_FULL) && (win.be != BE_NONE)) begin
                        state_d = RMW_WAIT;
                    end
                end
            end
            RD_WAIT:  state_d = IDLE;
            RMW_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs: all forced low in reset so an in-flight read or RMW is dropped.
    always_comb begin
        bus.p0_gnt         = 1'b0;
        bus.p1_gnt         = 1'b0;
        bus.p0_rvalid      = 1'b0;
        bus.p1_rvalid      = 1'b0;
        bus.p0_rdata       = 32'h0;
        bus.p1_rdata       = 32'h0;
        bus.p0_err         = 1'b0;
        bus.p1_err         = 1'b0;
        bus.mem_address    = 32'h0;
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = 32'h0;
        if (!reset) begin
            bus.p0_gnt    = gnt0;
            bus.p1_gnt    = gnt1;
            bus.p0_err    = err_q[0];
            bus.p1_err    = err_q[1];
            bus.p0_rvalid = oor_rv_q[0];
            bus.p1_rvalid = oor_rv_q[1];
            case (state_q)
                IDLE: begin
                    if (any_gnt && !win_oor) begin
                        if (!win.we) begin
                            bus.mem_read_en = 1'b1;
                            bus.mem_address = {win.idx, 2'b00};
                        end else if (win.be == BE_FULL) begin
                            bus.mem_write_en   = 1'b1;
                            bus.mem_address    = {win.idx, 2'b00};
                            bus.mem_write_data = win.wdata;
                        end else if (win.be != BE_NONE) begin
                            bus.mem_read_en = 1'b1;
                            bus.mem_address = {win.idx, 2'b00};
                        end
                    end
                end
                RD_WAIT: begin
                    if (owner_q) begin
                        bus.p1_rvalid = 1'b1;
                        bus.p1_rdata  = bus.mem_read_data;
                    end else begin
                        bus.p0_rvalid = 1'b1;
                        bus.p0_rdata  = bus.mem_read_data;
                    end
                end
                RMW_WAIT: begin
                    bus.mem_write_en   = 1'b1;
                    bus.mem_address    = {txn_q.idx, 2'b00};
                    bus.mem_write_data = merged;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, cycle-level reference checker, vectors and random traffic.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port synchronous-read memory, 256 x 32.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            bus.mem_read_data <= 32'h0;
        end else begin
            if (bus.mem_write_en) mem[bus.mem_address[9:2]] <= bus.mem_write_data;
            if (bus.mem_read_en)  bus.mem_read_data <= mem[bus.mem_address[9:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_p(input int p, input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_be = be; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_be = be; bus.p1_wdata = wd;
        end
    endtask

    // Reference model: transaction-level view of grants, responses and memory contents.
    logic [31:0] ref_mem [0:255];
    int          m_last;
    bit          m_busy, m_resp_v, m_resp_rv, m_resp_err, m_rmw_v;
    int          m_resp_port, m_rmw_idx;
    logic [31:0] m_resp_rdata, m_rmw_val;

    initial begin
        m_last = 1; m_busy = 0; m_resp_v = 0; m_rmw_v = 0;
        forever begin
            logic [1:0]  eg, erv, eerr, een;
            logic [31:0] erd [2];
            logic [31:0] eaddr, ewd, a, wd, mv;
            logic [3:0]  be;
            logic        we, busy_now;
            int          w;
            longint unsigned idx;
            @(negedge clk);
            if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
            if (reset) begin
                check("reset_ctl", {30'h0, bus.p0_gnt, bus.p1_gnt}, 32'h0);
                check("reset_rsp", {28'h0, bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err}, 32'h0);
                check("reset_mem", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
                check("reset_rdata", bus.p0_rdata | bus.p1_rdata, 32'h0);
                m_last = 1; m_busy = 0; m_resp_v = 0; m_rmw_v = 0;
            end else begin
                eg = 2'b00; erv = 2'b00; eerr = 2'b00; een = 2'b00;
                erd[0] = 32'h0; erd[1] = 32'h0; eaddr = 32'h0; ewd = 32'h0;
                if (m_resp_v) begin
                    erv[m_resp_port]  = m_resp_rv;
                    eerr[m_resp_port] = m_resp_err;
                    erd[m_resp_port]  = m_resp_rdata;
                end
                if (m_rmw_v) begin
                    een[0] = 1'b1; eaddr = 32'(m_rmw_idx * 4); ewd = m_rmw_val;
                    ref_mem[m_rmw_idx] = m_rmw_val;
                end
                busy_now = m_busy;
                m_busy = 0; m_resp_v = 0; m_rmw_v = 0;
                if (!busy_now && (bus.p0_req || bus.p1_req)) begin
                    if (bus.p0_req && bus.p1_req) w = (m_last == 0) ? 1 : 0;
                    else                          w = bus.p1_req ? 1 : 0;
                    m_last = w;
                    eg[w] = 1'b1;
                    we = w ? bus.p1_we : bus.p0_we;
                    a  = w ? bus.p1_addr : bus.p0_addr;
                    be = w ? bus.p1_be : bus.p0_be;
                    wd = w ? bus.p1_wdata : bus.p0_wdata;
                    idx = longint'(a) / 4;
                    if (idx >= 256) begin
                        m_resp_v = 1; m_resp_port = w; m_resp_err = 1; m_resp_rv = !we; m_resp_rdata = 32'h0;
                    end else if (!we) begin
                        een[1] = 1'b1; eaddr = 32'(idx * 4); m_busy = 1;
                        m_resp_v = 1; m_resp_port = w; m_resp_err = 0; m_resp_rv = 1;
                        m_resp_rdata = ref_mem[idx];
                    end else if (be == 4'hF) begin
                        een[0] = 1'b1; eaddr = 32'(idx * 4); ewd = wd; ref_mem[idx] = wd;
                    end else if (be != 4'h0) begin
                        een[1] = 1'b1; eaddr = 32'(idx * 4); m_busy = 1;
                        mv = ref_mem[idx];
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mv = (mv & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
                        m_rmw_v = 1; m_rmw_idx = int'(idx); m_rmw_val = mv;
                    end
                end
                check("gnt", {30'h0, bus.p1_gnt, bus.p0_gnt}, {30'h0, eg});
                check("rvalid_err", {28'h0, bus.p1_rvalid, bus.p0_rvalid, bus.p1_err, bus.p0_err},
                      {28'h0, erv, eerr});
                check("p0_rdata", bus.p0_rdata, erd[0]);
                check("p1_rdata", bus.p1_rdata, erd[1]);
                check("mem_en", {30'h0, bus.mem_read_en, bus.mem_write_en}, {30'h0, een});
                if (een != 2'b00) check("mem_addr", bus.mem_address, eaddr);
                if (een[0])       check("mem_wdata", bus.mem_write_data, ewd);
            end
        end
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_rv;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    // One isolated transaction; compares the owner's response with the table.
    task automatic run_vec(input int k, input vec_t v);
        logic got = 1'b0;
        @(posedge clk); #1;
        set_p(v.port, 1'b1, v.we, v.addr, v.be, v.wdata);
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = v.port ? bus.p1_gnt : bus.p0_gnt;
            if (!got) begin @(posedge clk); #1; end
        end
        check($sformatf("vec%0d_gnt", k), {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        set_p(v.port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check($sformatf("vec%0d_rv_err", k),
              v.port ? {30'h0, bus.p1_rvalid, bus.p1_err} : {30'h0, bus.p0_rvalid, bus.p0_err},
              {30'h0, v.exp_rv, v.exp_err});
        check($sformatf("vec%0d_rdata", k), v.port ? bus.p1_rdata : bus.p0_rdata, v.exp_rdata);
        $display("vec %0d port=%0d we=%0b addr=%h be=%h", k, v.port, v.we, v.addr, v.be);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          prev, last_c, ngr, who;
        logic        rq [2];
        logic        gd [2];
        logic [31:0] ra;
        logic [3:0]  rb;
        vecs[0]  = '{0, 1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1, 1'b0, 32'h010, 4'h0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 32'h080, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1, 1'b1, 32'h080, 4'h5, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{0, 1'b0, 32'h080, 4'h0, 32'h0,        1'b1, 1'b0, 32'h11BB33DD};
        vecs[5]  = '{0, 1'b0, 32'h400, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[6]  = '{1, 1'b1, 32'h404, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1, 1'b1, 32'h010, 4'h0, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1, 1'b0, 32'h010, 4'h0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[9]  = '{0, 1'b1, 32'h013, 4'h8, 32'h77000000, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1, 1'b0, 32'h010, 4'h0, 32'h0,        1'b1, 1'b0, 32'h77ADBEEF};
        vecs[11] = '{0, 1'b0, 32'hFFC, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[12] = '{0, 1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1, 1'b0, 32'h3FE, 4'h0, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};

        mem_clr = 1'b1; reset = 1'b1;
        set_p(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 mem_clr = 1'b0; reset = 1'b0;

        for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

        // Both ports read continuously: grants alternate, one every two cycles.
        @(posedge clk); #1;
        set_p(0, 1'b1, 1'b0, 32'h010, 4'h0, 32'h0);
        set_p(1, 1'b1, 1'b0, 32'h080, 4'h0, 32'h0);
        prev = -1; last_c = -1; ngr = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.p0_gnt || bus.p1_gnt) begin
                who = bus.p1_gnt ? 1 : 0;
                if (prev >= 0) begin
                    check("alt_order", who, 1 - prev);
                    check("alt_spacing", c - last_c, 2);
                end
                $display("alt grant cycle=%0d port=%0d", c, who);
                prev = who; last_c = c; ngr++;
            end
            @(posedge clk); #1;
        end
        check("alt_count", ngr, 8);
        set_p(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);

        // Reset lands on the write half of an RMW: the write must be dropped.
        #1 set_p(1, 1'b1, 1'b1, 32'h010, 4'h1, 32'h000000FF);
        @(negedge clk); check("rmw_gnt", {31'h0, bus.p1_gnt}, 32'h1);
        @(posedge clk); #1 set_p(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); reset = 1'b1;
        @(negedge clk); check("rst_rmw_we", {31'h0, bus.mem_write_en}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        set_p(0, 1'b1, 1'b0, 32'h010, 4'h0, 32'h0);
        set_p(1, 1'b1, 1'b0, 32'h010, 4'h0, 32'h0);
        @(negedge clk); check("rst_tie", {30'h0, bus.p0_gnt, bus.p1_gnt}, 32'h2);
        @(posedge clk); #1 set_p(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); check("rst_word_kept", bus.p0_rdata, 32'h77ADBEEF);
        @(posedge clk); #1;
        @(negedge clk); check("pending_p1_gnt", {31'h0, bus.p1_gnt}, 32'h1);
        @(posedge clk); #1 set_p(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); check("pending_p1_rdata", bus.p1_rdata, 32'h77ADBEEF);
        $display("reset-in-rmw sequence done");

        // Empty write occupies only its grant cycle.
        @(posedge clk); #1 set_p(1, 1'b1, 1'b1, 32'h020, 4'h0, 32'h55555555);
        @(negedge clk); check("empty_gnt", {31'h0, bus.p1_gnt}, 32'h1);
        @(posedge clk); #1 set_p(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p(0, 1'b1, 1'b0, 32'h020, 4'h0, 32'h0);
        @(negedge clk); check("after_empty_gnt", {31'h0, bus.p0_gnt}, 32'h1);
        check("empty_no_rsp", {30'h0, bus.p1_rvalid, bus.p1_err}, 32'h0);
        @(posedge clk); #1 set_p(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); check("after_empty_rdata", bus.p0_rdata, 32'h0);
        $display("empty-write sequence done");

        // Random traffic from both ports, judged by the reference model.
        rq[0] = 1'b0; rq[1] = 1'b0; gd[0] = 1'b0; gd[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || gd[p]) begin
                    rq[p] = ($urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 15) == 0)
                        ra = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFC : 32'h400 + 32'($urandom_range(0, 255) * 4);
                    else
                        ra = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0:       rb = 4'hF;
                        1:       rb = 4'h0;
                        default: rb = 4'($urandom_range(0, 15));
                    endcase
                    set_p(p, rq[p], 1'($urandom_range(0, 1)), ra, rb, $urandom);
                end
            end
            @(negedge clk);
            gd[0] = bus.p0_gnt; gd[1] = bus.p1_gnt;
        end
        $display("random phase done");
        @(posedge clk); #1 reset = 1'b0;
        set_p(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
